// File: rtl/mc14500_sequencer.sv
// Program sequencer for the MC14500 ICU: program counter, return stack and halt control.
// Program memory is read combinationally; one instruction executes per X2 cycle.
module mc14500_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              X2,
  input  logic              RST_N,
  input  logic              RUN,
  input  logic              JMP,
  input  logic              RTN,
  input  logic              FLAG_F,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [ADDR_W+3:0] MEM_DATA,
  output logic [3:0]        I,
  output logic [ADDR_W-1:0] IO_ADDR,
  output logic              HALTED,
  output logic              STK_ERR
);

  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               err_q, err_d;
  logic               push;
  logic [ADDR_W-1:0]  stack [STACK_DEPTH];
  logic [ADDR_W-1:0]  top;
  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  operand;

  assign opcode   = MEM_DATA[ADDR_W+3:ADDR_W];
  assign operand  = MEM_DATA[ADDR_W-1:0];
  assign pc_inc   = pc_q + ADDR_W'(1);
  // ptr_q indexes the next free slot; once full it points at the oldest entry,
  // so a push into a full stack overwrites the oldest value naturally.
  assign top      = stack[ptr_q - PTR_W'(1)];
  assign MEM_ADDR = pc_q;
  assign STK_ERR  = err_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    push    = 1'b0;
    I       = 4'h0;
    IO_ADDR = '0;
    HALTED  = 1'b0;
    case (state_q)
      S_RUN: begin
        I       = opcode;
        IO_ADDR = operand;
        if (FLAG_F) begin
          pc_d    = pc_inc;
          state_d = S_HALT;
        end else if (JMP) begin
          push  = 1'b1;
          pc_d  = operand;
          ptr_d = ptr_q + PTR_W'(1);
          if (sp_q == SP_FULL) err_d = 1'b1;
          else                 sp_d  = sp_q + SP_W'(1);
        end else if (RTN) begin
          if (sp_q == '0) begin
            pc_d  = '0;
            err_d = 1'b1;
          end else begin
            pc_d  = top;
            ptr_d = ptr_q - PTR_W'(1);
            sp_d  = sp_q - SP_W'(1);
          end
        end else begin
          pc_d = pc_inc;
        end
      end
      S_HALT: begin
        HALTED = 1'b1;
        if (RUN) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge X2 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      sp_q    <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // Stack storage needs no reset: SP/pointer reset makes old contents unreachable.
  always_ff @(posedge X2) begin
    if (push) stack[ptr_q] <= pc_inc;
  end

endmodule
